// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS channel word aligner and 10b->8b decoder; `define TMDS_STATS_EN adds slip/unlock counters
module tmds_channel_decoder #(
  parameter int C_token_count = 8,
  parameter int C_search_timeout = 2048,
  parameter int C_lock_loss = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked,
  output logic [3:0] offset
`ifdef TMDS_STATS_EN
  ,
  output logic [7:0] stat_slips,
  output logic [7:0] stat_unlocks
`endif
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state;
  logic [9:0] prev, w, w_r;
  logic [19:0] sh;
  logic [7:0] x, d, tok_run, tok_run_n;
  logic [15:0] timer;
  logic [1:0] tok_ctrl;
  logic tok, lock_evt, slip, unlock, lock_now;
  assign sh = {tmds_in, prev} >> offset;
  assign w = sh[9:0];
  assign x = w_r[9] ? ~w_r[7:0] : w_r[7:0];
  assign d = {x[7:1] ^ x[6:0] ^ {7{~w_r[8]}}, x[0]};
  assign tok = w_r inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  assign tok_ctrl = w_r == 10'b1101010100 ? 2'b00 :
                    w_r == 10'b0010101011 ? 2'b01 :
                    w_r == 10'b0101010100 ? 2'b10 : 2'b11;
  assign tok_run_n = tok ? tok_run + {7'd0, tok_run != 8'hff} : 8'd0;
  assign lock_evt = state == SEARCH && tok_run_n == 8'(C_token_count);
  assign slip = state == SEARCH && !lock_evt && timer == 16'(C_search_timeout - 1);
  assign unlock = state == LOCKED && !tok && timer == 16'(C_lock_loss - 1);
  // next-cycle lock state gates the output register so locked and outputs change together
  assign lock_now = state == LOCKED ? !unlock : lock_evt;
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= SEARCH;
      prev <= '0;
      w_r <= '0;
      offset <= '0;
      timer <= '0;
      tok_run <= '0;
      data_out <= '0;
      ctrl_out <= '0;
      de_out <= 1'b0;
      locked <= 1'b0;
    end else begin
      prev <= tmds_in;
      w_r <= w;
      data_out <= lock_now && !tok ? d : 8'd0;
      de_out <= lock_now && !tok;
      ctrl_out <= !lock_now ? 2'b00 : tok ? tok_ctrl : ctrl_out;
      locked <= lock_now;
      if (state == SEARCH) begin
        tok_run <= tok_run_n;
        if (lock_evt) begin
          state <= LOCKED;
          timer <= '0;
        end else if (slip) begin
          offset <= offset == 4'd9 ? 4'd0 : offset + 4'd1;
          timer <= '0;
          tok_run <= '0;
        end else
          timer <= timer + 16'd1;
      end else if (unlock) begin
        state <= SEARCH;
        tok_run <= '0;
        timer <= '0;
      end else
        timer <= tok ? 16'd0 : timer + 16'd1;
    end
  end
`ifdef TMDS_STATS_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      stat_slips <= '0;
      stat_unlocks <= '0;
    end else begin
      stat_slips <= stat_slips + {7'd0, slip && stat_slips != 8'hff};
      stat_unlocks <= stat_unlocks + {7'd0, unlock && stat_unlocks != 8'hff};
    end
  end
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: randomized scoreboard bench against a bitstream-level reference model
module tb_tmds_channel_decoder;
  localparam int TC = 8;
  localparam int ST = 2048;
  localparam int LL = 4096;
  localparam int HMAX = 40000;
  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ctrl;
    logic de;
    logic lk;
    logic [3:0] off;
    logic [7:0] slips;
    logic [7:0] unl;
  } exp_t;
  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic de_out, locked;
  logic [3:0] offset;
  logic [7:0] stat_slips, stat_unlocks;
  int vectors = 0;
  int miscompares = 0;
  logic [9:0] hist [HMAX];
  logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  exp_t q[$];
  int cyc = 2;
  int m_state = 0, m_timer = 0, m_run = 0, m_off = 0, m_off_d = 0, m_slips = 0, m_unl = 0;
  logic [1:0] m_ctrl = '0;

  tmds_channel_decoder dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .tmds_in(tmds_in),
    .data_out(data_out),
    .ctrl_out(ctrl_out),
    .de_out(de_out),
    .locked(locked),
    .offset(offset)
`ifdef TMDS_STATS_EN
    ,
    .stat_slips(stat_slips),
    .stat_unlocks(stat_unlocks)
`endif
  );
`ifndef TMDS_STATS_EN
  assign stat_slips = '0;
  assign stat_unlocks = '0;
`endif

  always #5 clk_pixel = ~clk_pixel;

  function automatic int tok_idx(input logic [9:0] v);
    for (int i = 0; i < 4; i++) if (v == toks[i]) return i;
    return -1;
  endfunction

  function automatic logic sbit(input int i);
    logic [9:0] v;
    v = hist[i / 10];
    return v[i % 10];
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] v);
    logic [7:0] xx, dd;
    xx = v[9] ? ~v[7:0] : v[7:0];
    dd[0] = xx[0];
    for (int i = 1; i < 8; i++) dd[i] = v[8] ? xx[i] ^ xx[i-1] : ~(xx[i] ^ xx[i-1]);
    return dd;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] v;
    do v = 10'($urandom_range(0, 1023)); while (tok_idx(v) >= 0);
    return v;
  endfunction

  // repeating serial stream of token t whose word phase is skewed by s bits
  function automatic logic [9:0] frame(input logic [9:0] t, input int s);
    logic [9:0] v;
    for (int j = 0; j < 10; j++) v[j] = t[(j + s) % 10];
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", n, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] word, input logic r);
    exp_t e;
    logic [9:0] aw;
    int ti;
    @(negedge clk_pixel);
    #1;
    tmds_in = word;
    reset = r;
    hist[cyc] = word;
    e = '0;
    if (r) begin
      hist[cyc] = '0;
      hist[cyc-1] = '0;
      m_state = 0; m_timer = 0; m_run = 0; m_off = 0; m_off_d = 0;
      m_slips = 0; m_unl = 0; m_ctrl = '0;
    end else begin
      for (int j = 0; j < 10; j++) aw[j] = sbit(10 * (cyc - 2) + m_off_d + j);
      m_off_d = m_off;
      ti = tok_idx(aw);
      if (m_state == 0) begin
        m_run = ti >= 0 ? (m_run < 255 ? m_run + 1 : 255) : 0;
        if (m_run == TC) begin
          m_state = 1;
          m_timer = 0;
        end else if (m_timer == ST - 1) begin
          m_off = (m_off + 1) % 10;
          m_timer = 0;
          m_run = 0;
          if (m_slips < 255) m_slips++;
        end else m_timer++;
      end else if (ti >= 0) m_timer = 0;
      else if (m_timer == LL - 1) begin
        m_state = 0;
        m_run = 0;
        m_timer = 0;
        if (m_unl < 255) m_unl++;
      end else m_timer++;
      e.lk = m_state == 1;
      m_ctrl = !e.lk ? 2'b00 : ti >= 0 ? 2'(ti) : m_ctrl;
      e.ctrl = m_ctrl;
      e.de = e.lk && ti < 0;
      e.data = e.de ? dec(aw) : 8'd0;
      e.off = 4'(m_off);
      e.slips = 8'(m_slips);
      e.unl = 8'(m_unl);
    end
    q.push_back(e);
    cyc++;
  endtask

  always @(negedge clk_pixel) begin
    exp_t e;
    exp_t g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {data_out, ctrl_out, de_out, locked, offset, stat_slips, stat_unlocks};
`ifndef TMDS_STATS_EN
      e.slips = '0;
      e.unl = '0;
`endif
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL out t=%0t got d=%h c=%b de=%b lk=%b off=%0d s=%0d u=%0d expected d=%h c=%b de=%b lk=%b off=%0d s=%0d u=%0d",
                 $time, g.data, g.ctrl, g.de, g.lk, g.off, g.slips, g.unl,
                 e.data, e.ctrl, e.de, e.lk, e.off, e.slips, e.unl);
      end
    end
  end

  initial begin
    hist[0] = '0;
    hist[1] = '0;
    repeat (4) step(toks[0], 1'b1);
    repeat (20) step(toks[0], 1'b0);
    chk("aligned_lock", {26'd0, locked, offset, de_out}, {26'd0, 1'b1, 4'd0, 1'b0});
    chk("aligned_ctrl", {30'd0, ctrl_out}, 32'd0);
    step(10'b0100000000, 1'b0);
    step(10'b1000000000, 1'b0);
    step(10'b0111111111, 1'b0);
    repeat (200) step($urandom_range(0, 3) == 0 ? toks[$urandom_range(0, 3)] : rnd_data(), 1'b0);
    for (int l = 0; l < 2; l++) begin
      repeat (640) step(rnd_data(), 1'b0);
      for (int k = 0; k < 160; k++) step(toks[k % 2], 1'b0);
    end
    chk("line_hold", {31'd0, locked}, 32'd1);
    repeat (4100) step(rnd_data(), 1'b0);
    chk("loss_unlock", {27'd0, locked, offset}, {27'd0, 1'b0, 4'd0});
`ifdef TMDS_STATS_EN
    chk("stat_unlocks", {24'd0, stat_unlocks}, 32'd1);
`endif
    repeat (30) step(rnd_data(), 1'b0);
    repeat (2) step(toks[1], 1'b1);
    repeat (7 * ST + 60) step(frame(toks[1], 3), 1'b0);
    chk("mis_lock7", {25'd0, locked, offset, ctrl_out}, {25'd0, 1'b1, 4'd7, 2'b01});
`ifdef TMDS_STATS_EN
    chk("stat_slips", {24'd0, stat_slips}, 32'd7);
`endif
    repeat (2) step(toks[1], 1'b1);
    repeat (5 * ST + 60) step(frame(toks[1], 5), 1'b0);
    chk("lock5", {27'd0, locked, offset}, {27'd0, 1'b1, 4'd5});
    step(frame(toks[1], 5), 1'b1);
    step(frame(toks[1], 5), 1'b0);
    chk("midlock_reset", {16'd0, locked, offset, data_out, ctrl_out, de_out},
        {16'd0, 1'b0, 4'd0, 8'd0, 2'b00, 1'b0});
    repeat (5) step(frame(toks[1], 5), 1'b0);
    @(negedge clk_pixel);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
